irq_apb_sequencer: RTL

APB master that drives the interrupt_controller_v2 register interface autonomously: boot-time mask programming, interrupt status fetch, per-source service handshake, and pending-bit clearing.
Sits between the interrupt controller's APB slave port and the service logic (CPU stub / handler FSMs).
Replaces hand-driven APB traffic from the bench in system-level configurations.

---
 rtl/irq_seq_pkg.sv | 22 ++
 rtl/apb_master_phase.sv | 74 +++++++
 rtl/irq_apb_sequencer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/irq_seq_pkg.sv
// rtl/irq_seq_pkg.sv - shared constants for the interrupt APB sequencer
// Contents: main FSM state encoding, APB direction values, default register map.
package irq_seq_pkg;

  // Main FSM states
  localparam logic [2:0] ST_INIT    = 3'd0;
  localparam logic [2:0] ST_IDLE    = 3'd1;
  localparam logic [2:0] ST_CONFIG  = 3'd2;
  localparam logic [2:0] ST_READ    = 3'd3;
  localparam logic [2:0] ST_SERVICE = 3'd4;
  localparam logic [2:0] ST_CLEAR   = 3'd5;

  // APB transfer direction
  localparam logic APB_READ  = 1'b0;
  localparam logic APB_WRITE = 1'b1;

  // Default interrupt controller register map
  localparam logic [31:0] DEF_CTRL_ADDR   = 32'h0;
  localparam logic [31:0] DEF_STATUS_ADDR = 32'h4;
  localparam logic [31:0] DEF_CLEAR_ADDR  = 32'h8;

endpackage

// File: rtl/apb_master_phase.sv
// rtl/apb_master_phase.sv - single-transfer APB master with ACCESS timeout
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   start, write, addr, wdata      launch one transfer (sampled only when bus idle)
//   done, rdata, err               completion strobe (combinational), read data, error
//   psel, penable, pwrite,
//   paddr, pwdata                  APB request outputs
//   prdata, pready, pslverr        APB response inputs
module apb_master_phase #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] access_cnt;
  logic             completing;
  logic             timeout_hit;

  // access_cnt holds the number of ACCESS cycles already spent without pready,
  // so the last permitted ACCESS cycle is the one where it reads TIMEOUT_CYC-1.
  assign completing  = penable && pready;
  assign timeout_hit = penable && !pready && (access_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign done        = completing || timeout_hit;
  assign err         = (completing && pslverr) || timeout_hit;
  assign rdata       = prdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
      access_cnt <= '0;
    end else if (penable) begin
      if (done) begin
        psel    <= 1'b0;
        penable <= 1'b0;
        pwrite  <= 1'b0;
        paddr   <= '0;
        pwdata  <= '0;
      end else begin
        access_cnt <= access_cnt + CNT_W'(1);
      end
    end else if (psel) begin
      penable    <= 1'b1;
      access_cnt <= '0;
    end else if (start) begin
      psel   <= 1'b1;
      pwrite <= write;
      paddr  <= addr;
      pwdata <= wdata;
    end
  end

endmodule

// File: rtl/irq_apb_sequencer.sv
// rtl/irq_apb_sequencer.sv - autonomous APB master for the interrupt controller
// Ports:
//   pclk_i, rst_n_i                        clock, asynchronous active-low reset
//   psel_o, penable_o, pwrite_o,
//   paddr_o, pwdata_o                      APB request to the controller
//   prdata_i, pready_i, pslverr_i          APB response
//   interrupt_i                            level interrupt from the controller
//   cfg_valid_i, cfg_mask_i, cfg_ready_o   mask rewrite handshake
//   svc_req_o, svc_id_o, svc_ack_i         per-source service handshake
//   err_o, spurious_o                      one-cycle event pulses
module irq_apb_sequencer
  import irq_seq_pkg::*;
#(
  parameter int                 NUM_IRQ     = 4,
  parameter logic [NUM_IRQ-1:0] INIT_MASK   = 4'hF,
  parameter logic [31:0]        CTRL_ADDR   = DEF_CTRL_ADDR,
  parameter logic [31:0]        STATUS_ADDR = DEF_STATUS_ADDR,
  parameter logic [31:0]        CLEAR_ADDR  = DEF_CLEAR_ADDR,
  parameter int                 TIMEOUT_CYC = 16,
  localparam int                ID_W        = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               pclk_i,
  input  logic               rst_n_i,
  output logic               psel_o,
  output logic               penable_o,
  output logic               pwrite_o,
  output logic [31:0]        paddr_o,
  output logic [31:0]        pwdata_o,
  input  logic [31:0]        prdata_i,
  input  logic               pready_i,
  input  logic               pslverr_i,
  input  logic               interrupt_i,
  input  logic               cfg_valid_i,
  input  logic [NUM_IRQ-1:0] cfg_mask_i,
  output logic               cfg_ready_o,
  output logic               svc_req_o,
  output logic [ID_W-1:0]    svc_id_o,
  input  logic               svc_ack_i,
  output logic               err_o,
  output logic               spurious_o
);

  logic [2:0]         state;
  logic [2:0]         state_nxt;
  logic [ID_W-1:0]    svc_id;
  logic               err_q;
  logic               spurious_q;

  logic               m_start;
  logic               m_write;
  logic [31:0]        m_addr;
  logic [31:0]        m_wdata;
  logic               m_done;
  logic [31:0]        m_rdata;
  logic               m_err;

  logic [NUM_IRQ-1:0] status;
  logic [ID_W-1:0]    first_id;
  logic               read_ok;
  logic               unused_rdata_bits;

  assign status            = m_rdata[NUM_IRQ-1:0];
  assign unused_rdata_bits = ^m_rdata[31:NUM_IRQ];
  assign read_ok           = (state == ST_READ) && m_done && !m_err;

  // Lowest set bit wins: scan downward so the last assignment is the lowest index.
  always_comb begin
    first_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (status[i]) first_id = ID_W'(i);
    end
  end

  // The transfer is launched in the same cycle the FSM decides to move, so
  // SETUP appears on the bus in the first cycle of the new state.
  always_comb begin
    state_nxt = state;
    m_start   = 1'b0;
    m_write   = APB_READ;
    m_addr    = '0;
    m_wdata   = '0;
    case (state)
      ST_INIT: begin
        // psel guards against relaunching while the boot write is in flight.
        if (!psel_o) begin
          m_start = 1'b1;
          m_write = APB_WRITE;
          m_addr  = CTRL_ADDR;
          m_wdata = {{(32 - NUM_IRQ){1'b0}}, INIT_MASK};
        end
        if (m_done) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (cfg_valid_i) begin
          m_start   = 1'b1;
          m_write   = APB_WRITE;
          m_addr    = CTRL_ADDR;
          m_wdata   = {{(32 - NUM_IRQ){1'b0}}, cfg_mask_i};
          state_nxt = ST_CONFIG;
        end else if (interrupt_i) begin
          m_start   = 1'b1;
          m_write   = APB_READ;
          m_addr    = STATUS_ADDR;
          state_nxt = ST_READ;
        end
      end
      ST_CONFIG: begin
        if (m_done) state_nxt = ST_IDLE;
      end
      ST_READ: begin
        if (m_done) begin
          state_nxt = (!m_err && (status != '0)) ? ST_SERVICE : ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (svc_ack_i) begin
          m_start   = 1'b1;
          m_write   = APB_WRITE;
          m_addr    = CLEAR_ADDR;
          m_wdata   = 32'd1 << svc_id;
          state_nxt = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (m_done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge pclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= ST_INIT;
      svc_id     <= '0;
      err_q      <= 1'b0;
      spurious_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      err_q      <= m_done && m_err;
      spurious_q <= read_ok && (status == '0);
      if (read_ok && (status != '0)) svc_id <= first_id;
    end
  end

  apb_master_phase #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_phase (
    .clk     (pclk_i),
    .rst_n   (rst_n_i),
    .start   (m_start),
    .write   (m_write),
    .addr    (m_addr),
    .wdata   (m_wdata),
    .done    (m_done),
    .rdata   (m_rdata),
    .err     (m_err),
    .psel    (psel_o),
    .penable (penable_o),
    .pwrite  (pwrite_o),
    .paddr   (paddr_o),
    .pwdata  (pwdata_o),
    .prdata  (prdata_i),
    .pready  (pready_i),
    .pslverr (pslverr_i)
  );

  assign cfg_ready_o = (state == ST_IDLE);
  assign svc_req_o   = (state == ST_SERVICE);
  assign svc_id_o    = svc_id;
  assign err_o       = err_q;
  assign spurious_o  = spurious_q;

endmodule
